wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//   Write-back stage driving the register-file write port. Merges single-cycle
//   EXE results and the multi-cycle divider result into one registered write
//   per cycle. Tracks the one outstanding divide and holds decode on RAW/WAW
//   hazards against it. Forwards the in-flight write onto the operand paths.
// PARAMETERS
//   CPU_WIDTH       32  data width; shared define, not overridden per instance
//   REG_ADDR_WIDTH  5   register address width; shared define
// PORTS
//   clk             in   1     clock
//   rst_n           in   1     reset, asynchronous, active-low
//   exe_wr_en_i     in   1     EXE result valid this cycle
//   exe_wr_addr_i   in   RAW   EXE destination rd
//   exe_wr_data_i   in   CW    EXE result
//   div_start_i     in   1     divide issued this cycle (one-cycle pulse)
//   div_rd_i        in   RAW   divide destination rd, sampled with div_start_i
//   div_ready_i     in   1     divider result valid (one-cycle pulse)
//   div_result_i    in   CW    divider result
//   flush_i         in   1     pipeline flush (jump/trap); divider flushed by same signal
//   id_rs1_i        in   RAW   decode rs1 address
//   id_rs2_i        in   RAW   decode rs2 address
//   id_rd_i         in   RAW   decode rd address
//   id_div_i        in   1     decode instruction is a divide
//   rf_rs1_data_i   in   CW    register-file read data, rs1
//   rf_rs2_data_i   in   CW    register-file read data, rs2
//   reg_wr_en_o     out  1     to register-file write enable
//   reg_wr_addr_o   out  RAW   to register-file write address
//   reg_wr_data_o   out  CW    to register-file write data
//   rs1_data_o      out  CW    forwarded rs1 operand
//   rs2_data_o      out  CW    forwarded rs2 operand
//   hold_o          out  1     stall decode
// BEHAVIOUR
//   Reset: reg_wr_en_o=0, reg_wr_addr_o=0, reg_wr_data_o=0; FSM=IDLE, pend_rd=0, skid empty.
//   Write register: 1-cycle latency; source selected in cycle N appears on reg_wr_*_o in N+1.
//   Priority per cycle: EXE > skid buffer > live div_ready_i. At most one write per cycle.
//   Any selected write with addr==0 gives reg_wr_en_o=0; data is don't-care.
//   reg_wr_en_o falls to 0 in any cycle with no source.
//   FSM states:
//     IDLE: div_start_i -> DIV_PEND, latch pend_rd=div_rd_i.
//     DIV_PEND:
//       div_ready_i & !exe_wr_en_i -> write result, go to IDLE.
//       div_ready_i & exe_wr_en_i  -> capture result in skid, go to DIV_HELD.
//       flush_i -> IDLE; any div_ready_i in the flush cycle is dropped.
//     DIV_HELD:
//       !exe_wr_en_i -> write skid, go to IDLE.
//       Otherwise stay in DIV_HELD.
//       flush_i does NOT discard the skid entry (result already committed).
//   div_start_i outside IDLE never occurs, because hold_o prevents it.
//   div_ready_i outside DIV_PEND is ignored.
//   hold_o = (state!=IDLE) & pend_rd!=0 & (id_rs1_i==pend_rd | id_rs2_i==pend_rd | id_rd_i==pend_rd)
//            | (state!=IDLE & id_div_i).
//     hold_o is combinational and is 0 during reset.
//   Forwarding: if reg_wr_en_o and rsX==reg_wr_addr_o!=0, rsX_data_o=reg_wr_data_o.
//     Otherwise rsX_data_o=rf_rsX_data_i. rsX==0 always gives 0.
//   Reset mid-operation: asserting rst_n low drops any pending divide and skid entry immediately.
// STRUCTURE
//   Shared package/defines: CPU_WIDTH, REG_ADDR_WIDTH, ZERO_REG.
//   FSM state encoding WB_IDLE/WB_DIV_PEND/WB_DIV_HELD is local localparam.
//   Sub-module wb_fwd_mux: combinational operand bypass, instanced twice (rs1/rs2).
//   FSM, skid register and write register live in wb_stage.
// TESTING
//   exe_wr_en_i=1, rd=5, data=0xA5A5_0001 -> next cycle reg_wr_en_o=1, addr=5, data=0xA5A5_0001.
//   exe write to rd=0 with data=0xFFFF_FFFF -> reg_wr_en_o stays 0.
//   div_start rd=7, then id_rs2_i=7 -> hold_o=1 until the cycle after the rd=7 write
//     is issued; div_ready data=0x0000_0003 -> reg wr rd=7 data=3.
//   div_ready coincident with exe write rd=3 -> cycle N+1 writes rd=3; N+2 writes rd=7
//     from skid; 3 consecutive EXE writes keep skid held with no loss.
//   div_start rd=9, flush_i with div_ready_i same cycle -> no write to rd=9; hold_o=0 next cycle.
//   reg_wr addr=4 data=0x1234 in flight, id_rs1_i=4, rf_rs1_data_i=0 -> rs1_data_o=0x1234.
//   rst_n low during DIV_HELD -> outputs 0 at once; after release no stale rd=7 write occurs.

Source files
------------

// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_stage_pkg
// Brief  : Shared widths, zero-register id and write-request type for WB.
// Rev    : 1.0
// ============================================================================
package wb_stage_pkg;

  localparam int CPU_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [CPU_WIDTH-1:0]      data;
  } wb_req_t;

  function automatic logic is_zero_reg(input logic [REG_ADDR_WIDTH-1:0] addr);
    return addr == ZERO_REG;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module : wb_fwd_mux
// Brief  : Operand bypass from the registered write port onto one read path.
// Rev    : 1.0
// ============================================================================
module wb_fwd_mux
  import wb_stage_pkg::*;
(
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr_i,
  input  logic [CPU_WIDTH-1:0]      rf_data_i,
  input  logic                      wr_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [CPU_WIDTH-1:0]      wr_data_i,
  output logic [CPU_WIDTH-1:0]      rs_data_o
);

  always_comb begin
    rs_data_o = rf_data_i;
    if (is_zero_reg(rs_addr_i)) begin
      rs_data_o = '0;
    end else if (wr_en_i && (wr_addr_i == rs_addr_i)) begin
      rs_data_o = wr_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module : wb_stage
// Brief  : Write-back merge of EXE and divider results, divide hazard hold,
//          and forwarding of the in-flight register-file write.
// Rev    : 1.0
// ============================================================================
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      exe_wr_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] exe_wr_addr_i,
  input  logic [CPU_WIDTH-1:0]      exe_wr_data_i,
  input  logic                      div_start_i,
  input  logic [REG_ADDR_WIDTH-1:0] div_rd_i,
  input  logic                      div_ready_i,
  input  logic [CPU_WIDTH-1:0]      div_result_i,
  input  logic                      flush_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_i,
  input  logic                      id_div_i,
  input  logic [CPU_WIDTH-1:0]      rf_rs1_data_i,
  input  logic [CPU_WIDTH-1:0]      rf_rs2_data_i,
  output logic                      reg_wr_en_o,
  output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_o,
  output logic [CPU_WIDTH-1:0]      reg_wr_data_o,
  output logic [CPU_WIDTH-1:0]      rs1_data_o,
  output logic [CPU_WIDTH-1:0]      rs2_data_o,
  output logic                      hold_o
);

  localparam logic [1:0] WB_IDLE     = 2'd0;
  localparam logic [1:0] WB_DIV_PEND = 2'd1;
  localparam logic [1:0] WB_DIV_HELD = 2'd2;

  logic [1:0]                r_state;
  logic [1:0]                w_state_nxt;
  logic [REG_ADDR_WIDTH-1:0] r_pend_rd;
  logic [CPU_WIDTH-1:0]      r_skid_data;
  logic                      w_skid_load;
  logic                      w_div_live;
  logic                      w_busy;
  wb_req_t                   w_sel;
  wb_req_t                   r_wr;

  // A divide result arriving in a flush cycle belongs to a squashed divide.
  assign w_div_live  = (r_state == WB_DIV_PEND) && div_ready_i && !flush_i;
  assign w_skid_load = w_div_live && exe_wr_en_i;

  always_comb begin
    w_sel = '0;
    if (exe_wr_en_i) begin
      w_sel.valid = 1'b1;
      w_sel.addr  = exe_wr_addr_i;
      w_sel.data  = exe_wr_data_i;
    end else if (r_state == WB_DIV_HELD) begin
      w_sel.valid = 1'b1;
      w_sel.addr  = r_pend_rd;
      w_sel.data  = r_skid_data;
    end else if (w_div_live) begin
      w_sel.valid = 1'b1;
      w_sel.addr  = r_pend_rd;
      w_sel.data  = div_result_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WB_IDLE: begin
        if (div_start_i) w_state_nxt = WB_DIV_PEND;
      end
      WB_DIV_PEND: begin
        if (flush_i)          w_state_nxt = WB_IDLE;
        else if (div_ready_i) w_state_nxt = exe_wr_en_i ? WB_DIV_HELD : WB_IDLE;
      end
      WB_DIV_HELD: begin
        // The skid entry is already committed, so flush leaves it alone.
        if (!exe_wr_en_i) w_state_nxt = WB_IDLE;
      end
      default: w_state_nxt = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WB_IDLE;
      r_pend_rd   <= '0;
      r_skid_data <= '0;
      r_wr        <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == WB_IDLE) && div_start_i) r_pend_rd <= div_rd_i;
      if (w_skid_load) r_skid_data <= div_result_i;
      r_wr.valid <= w_sel.valid && !is_zero_reg(w_sel.addr);
      if (w_sel.valid) begin
        r_wr.addr <= w_sel.addr;
        r_wr.data <= w_sel.data;
      end
    end
  end

  assign reg_wr_en_o   = r_wr.valid;
  assign reg_wr_addr_o = r_wr.addr;
  assign reg_wr_data_o = r_wr.data;

  assign w_busy = (r_state != WB_IDLE);
  assign hold_o = w_busy &
                  ((!is_zero_reg(r_pend_rd) &
                    ((id_rs1_i == r_pend_rd) | (id_rs2_i == r_pend_rd) | (id_rd_i == r_pend_rd)))
                   | id_div_i);

  logic [REG_ADDR_WIDTH-1:0] w_rs_addr [2];
  logic [CPU_WIDTH-1:0]      w_rf_data [2];
  logic [CPU_WIDTH-1:0]      w_rs_data [2];

  assign w_rs_addr[0] = id_rs1_i;
  assign w_rs_addr[1] = id_rs2_i;
  assign w_rf_data[0] = rf_rs1_data_i;
  assign w_rf_data[1] = rf_rs2_data_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    wb_fwd_mux u_fwd_mux (
      .rs_addr_i (w_rs_addr[gi]),
      .rf_data_i (w_rf_data[gi]),
      .wr_en_i   (r_wr.valid),
      .wr_addr_i (r_wr.addr),
      .wr_data_i (r_wr.data),
      .rs_data_o (w_rs_data[gi])
    );
  end

  assign rs1_data_o = w_rs_data[0];
  assign rs2_data_o = w_rs_data[1];

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_stage
// Brief  : Self-checking bench for wb_stage (vector table plus scoreboard).
// Rev    : 1.0
// ============================================================================
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exe_wr_en_i = 1'b0;
  logic [4:0]  exe_wr_addr_i = '0;
  logic [31:0] exe_wr_data_i = '0;
  logic        div_start_i = 1'b0;
  logic [4:0]  div_rd_i = '0;
  logic        div_ready_i = 1'b0;
  logic [31:0] div_result_i = '0;
  logic        flush_i = 1'b0;
  logic [4:0]  id_rs1_i = '0;
  logic [4:0]  id_rs2_i = '0;
  logic [4:0]  id_rd_i = '0;
  logic        id_div_i = 1'b0;
  logic [31:0] rf_rs1_data_i = '0;
  logic [31:0] rf_rs2_data_i = '0;
  logic        reg_wr_en_o;
  logic [4:0]  reg_wr_addr_o;
  logic [31:0] reg_wr_data_o;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic        hold_o;

  wb_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .exe_wr_en_i   (exe_wr_en_i),
    .exe_wr_addr_i (exe_wr_addr_i),
    .exe_wr_data_i (exe_wr_data_i),
    .div_start_i   (div_start_i),
    .div_rd_i      (div_rd_i),
    .div_ready_i   (div_ready_i),
    .div_result_i  (div_result_i),
    .flush_i       (flush_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rd_i       (id_rd_i),
    .id_div_i      (id_div_i),
    .rf_rs1_data_i (rf_rs1_data_i),
    .rf_rs2_data_i (rf_rs2_data_i),
    .reg_wr_en_o   (reg_wr_en_o),
    .reg_wr_addr_o (reg_wr_addr_o),
    .reg_wr_data_o (reg_wr_data_o),
    .rs1_data_o    (rs1_data_o),
    .rs2_data_o    (rs2_data_o),
    .hold_o        (hold_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        exe_en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exp_en;
  } vec_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected write is queued with the stimulus and retired one edge later.
  task automatic tick(input string name, input logic en, input logic [4:0] addr,
                      input logic [31:0] data);
    exp_t e;
    exp_t g;
    e.en   = en;
    e.addr = addr;
    e.data = data;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    chk({name, ".wr_en"}, 32'(reg_wr_en_o), 32'(g.en));
    if (g.en) begin
      chk({name, ".wr_addr"}, 32'(reg_wr_addr_o), 32'(g.addr));
      chk({name, ".wr_data"}, reg_wr_data_o, g.data);
    end
  endtask

  task automatic chk_hold(input string name, input logic exp);
    #1;
    chk(name, 32'(hold_o), 32'(exp));
  endtask

  task automatic skid_seq(input string name, input int n_exe);
    div_start_i = 1'b1; div_rd_i = 5'd7;
    tick({name, ".start"}, 1'b0, 5'd0, 32'h0);
    div_start_i = 1'b0;
    div_ready_i = 1'b1; div_result_i = 32'h0000_0077;
    exe_wr_en_i = 1'b1; exe_wr_addr_i = 5'd3; exe_wr_data_i = 32'h0000_0033;
    tick({name, ".exe3"}, 1'b1, 5'd3, 32'h0000_0033);
    div_ready_i = 1'b0;
    for (int k = 0; k < n_exe; k++) begin
      exe_wr_addr_i = 5'(10 + k);
      exe_wr_data_i = 32'h0000_0100 + 32'(k);
      flush_i = (k == 1);
      id_rd_i = 5'd7;
      chk_hold({name, ".hold_held"}, 1'b1);
      tick({name, ".exe_more"}, 1'b1, 5'(10 + k), 32'h0000_0100 + 32'(k));
    end
    flush_i = 1'b0; exe_wr_en_i = 1'b0; id_rd_i = 5'd0;
    tick({name, ".skid_wr"}, 1'b1, 5'd7, 32'h0000_0077);
    tick({name, ".after"}, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    vecs[0] = '{1'b1, 5'd5,  32'hA5A5_0001, 1'b1};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{1'b0, 5'd9,  32'h1234_5678, 1'b0};
    vecs[3] = '{1'b1, 5'd31, 32'hDEAD_BEEF, 1'b1};
    vecs[4] = '{1'b1, 5'd1,  32'h0000_0000, 1'b1};

    // Reset state, with a decode divide present to show hold stays low.
    id_div_i = 1'b1;
    #2;
    chk("rst.wr_en", 32'(reg_wr_en_o), 32'h0);
    chk("rst.wr_addr", 32'(reg_wr_addr_o), 32'h0);
    chk("rst.wr_data", reg_wr_data_o, 32'h0);
    chk("rst.hold", 32'(hold_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    id_div_i = 1'b0;

    for (int i = 0; i < 5; i++) begin
      exe_wr_en_i   = vecs[i].exe_en;
      exe_wr_addr_i = vecs[i].rd;
      exe_wr_data_i = vecs[i].data;
      tick($sformatf("vec%0d", i), vecs[i].exp_en, vecs[i].rd, vecs[i].data);
    end

    // Forwarding from the in-flight write.
    exe_wr_en_i = 1'b1; exe_wr_addr_i = 5'd4; exe_wr_data_i = 32'h0000_1234;
    tick("fwd.wr4", 1'b1, 5'd4, 32'h0000_1234);
    exe_wr_en_i = 1'b0;
    id_rs1_i = 5'd4; rf_rs1_data_i = 32'h0; id_rs2_i = 5'd6; rf_rs2_data_i = 32'h0000_CAFE;
    #1;
    chk("fwd.rs1_hit", rs1_data_o, 32'h0000_1234);
    chk("fwd.rs2_miss", rs2_data_o, 32'h0000_CAFE);
    id_rs1_i = 5'd0; rf_rs1_data_i = 32'hFFFF_FFFF; id_rs2_i = 5'd4; rf_rs2_data_i = 32'h1;
    #1;
    chk("fwd.rs1_zero", rs1_data_o, 32'h0);
    chk("fwd.rs2_hit", rs2_data_o, 32'h0000_1234);
    tick("fwd.idle", 1'b0, 5'd0, 32'h0);
    id_rs1_i = 5'd4; rf_rs1_data_i = 32'h0000_0042;
    #1;
    chk("fwd.no_en", rs1_data_o, 32'h0000_0042);
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; rf_rs1_data_i = '0; rf_rs2_data_i = '0;

    // Divide to rd=7 with RAW hold until the write is issued.
    div_start_i = 1'b1; div_rd_i = 5'd7;
    chk_hold("div.hold_idle", 1'b0);
    tick("div.start", 1'b0, 5'd0, 32'h0);
    div_start_i = 1'b0; id_rs2_i = 5'd7;
    chk_hold("div.hold_raw", 1'b1);
    id_rs2_i = 5'd0; id_div_i = 1'b1;
    chk_hold("div.hold_div", 1'b1);
    id_div_i = 1'b0;
    chk_hold("div.hold_none", 1'b0);
    id_rs2_i = 5'd7;
    tick("div.wait", 1'b0, 5'd0, 32'h0);
    div_ready_i = 1'b1; div_result_i = 32'h0000_0003;
    chk_hold("div.hold_ready", 1'b1);
    tick("div.wr", 1'b1, 5'd7, 32'h0000_0003);
    div_ready_i = 1'b0;
    chk_hold("div.hold_clear", 1'b0);
    id_rs2_i = 5'd0;
    tick("div.idle", 1'b0, 5'd0, 32'h0);

    // A stray divider result in IDLE produces nothing.
    div_ready_i = 1'b1; div_result_i = 32'h0000_0BAD;
    tick("stray.ready", 1'b0, 5'd0, 32'h0);
    div_ready_i = 1'b0;

    skid_seq("skid0", 0);
    skid_seq("skid3", 3);

    // Flush drops the coincident divider result.
    div_start_i = 1'b1; div_rd_i = 5'd9;
    tick("flush.start", 1'b0, 5'd0, 32'h0);
    div_start_i = 1'b0;
    flush_i = 1'b1; div_ready_i = 1'b1; div_result_i = 32'h0000_0099; id_rs1_i = 5'd9;
    chk_hold("flush.hold", 1'b1);
    tick("flush.cycle", 1'b0, 5'd0, 32'h0);
    flush_i = 1'b0; div_ready_i = 1'b0;
    chk_hold("flush.hold_after", 1'b0);
    tick("flush.after", 1'b0, 5'd0, 32'h0);
    id_rs1_i = 5'd0;

    // Asynchronous reset while a result sits in the skid.
    div_start_i = 1'b1; div_rd_i = 5'd7;
    tick("rstm.start", 1'b0, 5'd0, 32'h0);
    div_start_i = 1'b0;
    div_ready_i = 1'b1; div_result_i = 32'h0000_0777;
    exe_wr_en_i = 1'b1; exe_wr_addr_i = 5'd3; exe_wr_data_i = 32'h0000_0333;
    tick("rstm.exe3", 1'b1, 5'd3, 32'h0000_0333);
    div_ready_i = 1'b0; exe_wr_addr_i = 5'd12; exe_wr_data_i = 32'h0000_0C0C; id_rd_i = 5'd7;
    chk_hold("rstm.hold_held", 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstm.wr_en", 32'(reg_wr_en_o), 32'h0);
    chk("rstm.wr_addr", 32'(reg_wr_addr_o), 32'h0);
    chk("rstm.wr_data", reg_wr_data_o, 32'h0);
    chk("rstm.hold", 32'(hold_o), 32'h0);
    rst_n = 1'b1;
    exe_wr_en_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick($sformatf("rstm.post%0d", j), 1'b0, 5'd0, 32'h0);
    end
    chk_hold("rstm.hold_post", 1'b0);

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
